// File: rtl/seq_shift_rotate_if.sv
// Handshake bundle for the multi-cycle shift/rotate unit: operand/command
// channel in, result channel out, plus the synchronous abort.
interface seq_shift_rotate_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_mode;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  // Requester side: issues operations and consumes results.
  modport master (
    output in_valid, in_data, in_shamt, in_mode, abort, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, abort, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );
endinterface

// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit. Performs at most MAX_STEP bit positions per
// clock, iterating until the requested amount is consumed, then holds the
// result until the consumer takes it. One operation in flight at a time.
module seq_shift_rotate #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 3
) (
  input logic              clk,
  input logic              rst_n,
  seq_shift_rotate_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  localparam logic [SHW-1:0] MAX_STEP_L = SHW'(MAX_STEP);
  localparam logic [SHW:0]   WIDTH_L    = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   rem_q,   rem_d;
  logic [2:0]       mode_q,  mode_d;
  logic             sign_q,  sign_d;
  logic             err_q,   err_d;

  logic [SHW-1:0]   step;

  // Positions to move this cycle: whatever remains, capped at MAX_STEP.
  function automatic logic [SHW-1:0] step_amount(input logic [SHW-1:0] rem);
    step_amount = (rem < MAX_STEP_L) ? rem : MAX_STEP_L;
  endfunction

  // One partial shift/rotate by k positions. SRA fills from the sign captured
  // at accept so the fill is right regardless of the intermediate MSB.
  function automatic logic [WIDTH-1:0] step_op(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       m,
                                               input logic [SHW-1:0]   k,
                                               input logic             sgn);
    logic [WIDTH-1:0] fill;
    logic [SHW:0]     back;
    fill = sgn ? ~({WIDTH{1'b1}} >> k) : '0;
    back = WIDTH_L - {1'b0, k};
    case (m)
      MODE_SLL: step_op = d << k;
      MODE_SRL: step_op = d >> k;
      MODE_SRA: step_op = (d >> k) | fill;
      MODE_ROL: step_op = (d << k) | (d >> back);
      MODE_ROR: step_op = (d >> k) | (d << back);
      default:  step_op = d;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [2:0] m);
    is_reserved = (m > MODE_ROR);
  endfunction

  assign step = step_amount(rem_q);

  // State and datapath registers; reset clears everything so no stale result
  // can ever be presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, wait for the consumer
  // in HOLD; abort wins over any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    err_d   = err_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_d = bus.in_data;
            mode_d = bus.in_mode;
            rem_d  = bus.in_shamt;
            sign_d = bus.in_data[WIDTH-1];
            err_d  = is_reserved(bus.in_mode);
            if (bus.in_shamt == '0 || is_reserved(bus.in_mode)) begin
              state_d = HOLD;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          data_d = step_op(data_q, mode_q, step, sign_q);
          rem_d  = rem_q - step;
          if (rem_q == step) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_zero  = (state_q == HOLD) && (data_q == '0);
  assign bus.out_err   = (state_q == HOLD) && err_q;

endmodule
